// File: rtl/if_stage.sv
// rtl/if_stage.sv - Instruction-fetch stage: PC generation, 1-cycle instruction RAM reads,
// output register plus one skid entry toward decode, redirect on br_taken.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        right_valid,
  input  logic        right_ready,
  output logic [31:0] right_pc,
  output logic [31:0] right_inst
);

  logic [31:0] req_pc_q, req_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  logic        fire;
  logic        out_free;
  logic        skid_next;
  logic [31:0] target_al;
  logic        unused_target_bits;

  assign unused_target_bits = ^br_target[1:0];

  always_comb begin
    req_pc_d     = req_pc_q;
    pend_pc_d    = pend_pc_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;

    target_al   = {br_target[31:2], 2'b00};
    right_valid = out_valid_q && !br_taken;
    fire        = right_valid && right_ready;
    out_free    = !out_valid_q || fire;

    // Returning word goes to out when possible, keeping skid ahead of it in order.
    if (pend_valid_q) begin
      if (!out_free) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = pend_pc_q;
        skid_inst_d  = inst_sram_rdata;
      end else if (skid_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = skid_pc_q;
        out_inst_d  = skid_inst_q;
        skid_pc_d   = pend_pc_q;
        skid_inst_d = inst_sram_rdata;
      end else begin
        out_valid_d = 1'b1;
        out_pc_d    = pend_pc_q;
        out_inst_d  = inst_sram_rdata;
      end
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pc_d     = skid_pc_q;
        out_inst_d   = skid_inst_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A full skid next cycle means nowhere to put another return, so hold off issuing.
    skid_next      = skid_valid_d;
    inst_sram_en   = !reset && (br_taken || !skid_next);
    inst_sram_addr = br_taken ? target_al : {req_pc_q[31:2], 2'b00};
    pend_valid_d   = inst_sram_en;

    if (br_taken) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      pend_pc_d    = target_al;
      req_pc_d     = target_al + 32'd4;
    end else if (inst_sram_en) begin
      pend_pc_d = req_pc_q;
      req_pc_d  = req_pc_q + 32'd4;
    end

    right_pc   = out_pc_q;
    right_inst = out_inst_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc_q     <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'd0;
      out_inst_q   <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_inst_q  <= 32'd0;
    end else begin
      req_pc_q     <= req_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - Self-checking bench for if_stage: in-flight queue model plus
// directed literal checks for reset, stall, redirect and wrap, then randomized traffic.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        right_valid;
  logic        right_ready;
  logic [31:0] right_pc;
  logic [31:0] right_inst;

  int   errors = 0;
  int   checks = 0;
  logic hash_mode;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .right_valid    (right_valid),
    .right_ready    (right_ready),
    .right_pc       (right_pc),
    .right_inst     (right_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a, input logic mode);
    return mode ? ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D) : a;
  endfunction

  // Synchronous instruction RAM: data appears the cycle after the request.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? ram_word(inst_sram_addr, hash_mode) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of requested-but-undelivered words in request order.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          cyc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] next_addr = RESET_PC;
  int          cyc = 0;
  logic        prev_reset = 1'b1;

  always @(negedge clk) begin
    logic        exp_rv;
    logic [31:0] al;
    if (reset) begin
      chk("reset_en", inst_sram_en, 1'b0);
      if (prev_reset) chk("reset_valid", right_valid, 1'b0);
      q.delete();
      next_addr  = RESET_PC;
      prev_reset = 1'b1;
    end else begin
      prev_reset = 1'b0;
      exp_rv = !br_taken && q.size() > 0 && q[0].cyc <= cyc - 2;
      chk("model_valid", right_valid, exp_rv);
      if (exp_rv) begin
        chk("model_pc", right_pc, q[0].pc);
        chk("model_inst", right_inst, q[0].inst);
        if (right_ready) void'(q.pop_front());
      end
      if (br_taken) begin
        al = {br_target[31:2], 2'b00};
        chk("model_br_en", inst_sram_en, 1'b1);
        chk("model_br_addr", inst_sram_addr, al);
        q.delete();
        q.push_back('{pc: al, inst: ram_word(al, hash_mode), cyc: cyc});
        next_addr = al + 32'd4;
      end else begin
        // Only two words may be held at once after this edge; request iff there is room.
        chk("model_en", inst_sram_en, q.size() < 2);
        if (inst_sram_en === 1'b1) begin
          chk("model_addr", inst_sram_addr, next_addr);
          q.push_back('{pc: next_addr, inst: ram_word(next_addr, hash_mode), cyc: cyc});
          next_addr = next_addr + 32'd4;
        end
      end
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int   n;
  logic dropped;

  initial begin
    reset = 1'b1; br_taken = 1'b0; br_target = 32'd0; right_ready = 1'b1; hash_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("first_req_en", inst_sram_en, 1'b1);
    chk("first_req_addr", inst_sram_addr, 32'h1C00_0000);
    n = 0;
    while (!right_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_latency", n, 2);
    chk("first_pc", right_pc, 32'h1C00_0000);
    chk("first_inst", right_inst, 32'h1C00_0000);
    @(negedge clk);
    chk("second_pc", right_pc, 32'h1C00_0004);

    @(posedge clk);
    #1 right_ready = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", right_valid, 1'b1);
      chk("stall_pc", right_pc, 32'h1C00_0008);
      if (i < 2 && !inst_sram_en) dropped = 1'b1;
    end
    chk("stall_en_drop", dropped, 1'b1);
    @(posedge clk);
    #1 right_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("resume_valid", right_valid, 1'b1);
      chk("resume_pc", right_pc, 32'h1C00_0008 + 32'(4 * k));
    end

    @(posedge clk);
    #1 right_ready = 1'b0;
    @(posedge clk);
    #1 br_taken = 1'b1; br_target = 32'h1C00_0103;
    @(negedge clk);
    chk("br_valid_low", right_valid, 1'b0);
    chk("br_addr", inst_sram_addr, 32'h1C00_0100);
    @(posedge clk);
    #1 br_taken = 1'b0; right_ready = 1'b1;
    @(negedge clk);
    chk("br_gap", right_valid, 1'b0);
    @(negedge clk);
    chk("br_tgt_valid", right_valid, 1'b1);
    chk("br_tgt_pc", right_pc, 32'h1C00_0100);
    @(negedge clk);
    chk("br_next_pc", right_pc, 32'h1C00_0104);

    @(posedge clk);
    #1 br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
    @(negedge clk);
    chk("wrap_addr", inst_sram_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1 br_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_pc0", right_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_pc1", right_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc2", right_pc, 32'h0000_0000);
    chk("wrap_inst2", right_inst, 32'h0000_0000);

    @(posedge clk);
    #1 hash_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      right_ready = ($urandom_range(0, 3) != 0);
      br_taken    = ($urandom_range(0, 49) == 0);
      br_target   = $urandom;
    end

    @(posedge clk);
    #1 br_taken = 1'b0; right_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; br_taken = 1'b1; br_target = 32'h0000_4000;
    @(posedge clk);
    #1 reset = 1'b0; br_taken = 1'b0; right_ready = 1'b1;
    @(negedge clk);
    chk("rerst_addr", inst_sram_addr, 32'h1C00_0000);
    chk("rerst_valid", right_valid, 1'b0);
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the CPU pipeline, sitting directly upstream of the decode stage. It owns the PC, issues one word-aligned read per cycle to the synchronous instruction RAM (1-cycle read latency), and buffers returned words in an output register plus one skid entry. It presents `{pc, inst}` to decode over a valid/ready handshake and restarts fetch on a redirect from downstream.

## Interface
Parameters:
- `RESET_PC`, 32'h1C00_0000, first fetch address after reset.

Ports:
- Clock is `clk`. Reset is `reset`, synchronous, active-high.
- `clk`  in  1  clock.
- `reset`  in  1  reset.
- `inst_sram_en`  out  1  read request this cycle.
- `inst_sram_addr`  out  32  read address; bits [1:0] always 0.
- `inst_sram_rdata`  in  32  data for the request issued in the previous cycle.
- `br_taken`  in  1  redirect fetch this cycle.
- `br_target`  in  32  redirect address; bits [1:0] ignored (treated as 0).
- `right_valid`  out  1  pc/inst valid to decode.
- `right_ready`  in  1  decode accepts this cycle.
- `right_pc`  out  32  PC of the presented instruction.
- `right_inst`  out  32  presented instruction word.

## Operation
- State:
  - `req_pc`: next sequential fetch address.
  - `pend_valid`/`pend_pc`: a request was issued last cycle.
  - `out_valid`/`out_pc`/`out_inst`: the presented slot.
  - `skid_valid`/`skid_pc`/`skid_inst`: overflow slot.
- `fire` = `right_valid && right_ready`.
- `out_free` = `!out_valid || fire`.
- Return handling when `pend_valid=1` and `br_taken=0`. The returning word is D = {`pend_pc`, `inst_sram_rdata`}.
  - If `out_free` and the skid is empty: out <= D.
  - If `out_free` and the skid is full: out <= skid, skid <= D.
  - If not `out_free`: skid <= D. The skid is guaranteed empty by the issue rule.
- When `pend_valid=0`, the skid is full and `out_free`: out <= skid, and the skid empties.
- When `out_free` and nothing is loaded into out: `out_valid` <= 0.
- Issue rule: `skid_next` is the value `skid_valid` will take at the next edge. It depends only on the current state and `fire`.
  - `inst_sram_en` = `!reset && (br_taken || !skid_next)`.
  - On a normal issue: `inst_sram_addr` = `req_pc`; `pend_pc` <= `req_pc`; `req_pc` <= `req_pc + 4`.
  - `pend_valid` <= `inst_sram_en`.
- Redirect (`br_taken=1`) has priority over everything:
  - `right_valid` is forced to 0 in that cycle, so there is no `fire`.
  - `out_valid`, `skid_valid` <= 0.
  - The returning `inst_sram_rdata` is discarded.
  - `inst_sram_en` = 1 and `inst_sram_addr` = {`br_target[31:2]`, 2'b00}.
  - `pend_pc` <= the aligned target; `req_pc` <= aligned target + 4.
- `right_valid` = `out_valid && !br_taken`; `right_pc` = `out_pc`; `right_inst` = `out_inst`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- At most 3 instructions are in flight (out, skid, pend). No word is ever dropped or duplicated except on redirect, where all in-flight words are dropped by design.

## Timing
- Reset (synchronous, applies at the clock edge):
  - `req_pc` = `RESET_PC`; all valids 0.
  - `inst_sram_en` = 0 while `reset` is high.
  - `right_pc` and `right_inst` are don't-care while `right_valid=0` (both registers reset to 0).
- First request: the first cycle after `reset` deasserts, address = `RESET_PC`. `right_valid` rises 2 cycles after that request.
- Latency from request to presentation is 2 cycles: one for the RAM read, one for the output register.
- Throughput: 1 instruction/cycle while `right_ready=1`; the skid stays empty.
- Stall on `right_ready=0`:
  - `right_valid`, `right_pc` and `right_inst` stay stable.
  - At most one more returning word lands in the skid.
  - `inst_sram_en` drops once the skid will be full.
  - After `right_ready` returns, the sequence resumes in order with no gaps or duplicates.
- Redirect: the target is requested in the same cycle as `br_taken`, and the target instruction is presented 2 cycles later.
- Back-to-back `br_taken` cycles: the last target wins.
- Reset asserted mid-stall or mid-redirect overrides everything.

## Test plan
- Reset release, `right_ready`=1 constantly; RAM word = address:
  - Requests go to 1C00_0000, 1C00_0004, … on consecutive cycles.
  - `right_valid` rises 2 cycles after the first request with pc = inst = 1C00_0000.
  - Then one instruction per cycle.
- Stall: hold `right_ready=0` for 5 cycles after pc 1C00_0008 is presented:
  - pc 1C00_0008 stays stable.
  - `inst_sram_en` drops within 2 cycles.
  - On release, 1C00_000C, 1C00_0010, … follow with no gap or duplicate.
- Redirect: `br_taken=1`, `br_target`=1C00_0103 while out and skid are full:
  - `right_valid`=0 that cycle.
  - Address is 1C00_0100 that cycle.
  - The next presented pc is 1C00_0100, followed by 1C00_0104.
- Redirect concurrent with stall (`right_ready=0`, `br_taken=1`): no `fire`, and the old out instruction is never presented again.
- Wrap: redirect to FFFF_FFF8 → presented pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Randomized `right_ready` for 1000 cycles against a scoreboard of the sequential pc stream:
  - Every pc is delivered exactly once, in order.
  - `right_inst` matches the RAM model.
